// File: rtl/qpi_mem_arbiter_if.sv
// Bus bundle between NREQ QPI requesters, the round-robin arbiter and the shared downstream port.
// The arbiter connects through the slave modport; the master modport is the requesters' and adapter's view.
interface qpi_mem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 25
);
    logic [NREQ-1:0]    s_do_read;
    logic [NREQ-1:0]    s_do_write;
    logic [NREQ*AW-1:0] s_addr;
    logic [NREQ*32-1:0] s_wdata;
    logic [31:0]        s_rdata;
    logic [NREQ-1:0]    s_next_word;
    logic [NREQ-1:0]    s_is_idle;

    logic               m_do_read;
    logic               m_do_write;
    logic [AW-1:0]      m_addr;
    logic [31:0]        m_wdata;
    logic [31:0]        m_rdata;
    logic               m_next_word;
    logic               m_is_idle;

    modport slave (
        input  s_do_read, s_do_write, s_addr, s_wdata,
        output s_rdata, s_next_word, s_is_idle,
        output m_do_read, m_do_write, m_addr, m_wdata,
        input  m_rdata, m_next_word, m_is_idle
    );

    modport master (
        output s_do_read, s_do_write, s_addr, s_wdata,
        input  s_rdata, s_next_word, s_is_idle,
        input  m_do_read, m_do_write, m_addr, m_wdata,
        output m_rdata, m_next_word, m_is_idle
    );
endinterface

// File: rtl/qpi_mem_arbiter.sv
// Round-robin arbiter sharing one QPI memory port between NREQ requesters.
// A grant lasts a whole burst and is released only after the downstream port reports idle.
module qpi_mem_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 25
) (
    input  logic                clk,
    input  logic                rst,
    qpi_mem_arbiter_if.slave    bus,
    output logic [1:0]          owner,
    output logic                busy
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      r_owner;
    logic [1:0]      r_rrPtr;

    logic [NREQ-1:0] w_req;
    logic            w_found;
    logic [1:0]      w_pick;
    logic            w_ownRead;
    logic            w_ownWrite;
    logic [AW-1:0]   w_ownAddr;
    logic [31:0]     w_ownWdata;
    logic [1:0]      w_nextPtr;
    logic            w_grant;

    assign w_req   = bus.s_do_read | bus.s_do_write;
    assign w_grant = (r_state == ST_GRANT);

    // Scan from rr_ptr upward; descending k lets the nearest requester overwrite farther ones.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_req[i] && (((int'(r_rrPtr) + k) % NREQ) == i)) begin
                    w_found = 1'b1;
                    w_pick  = 2'(i);
                end
            end
        end
    end

    always_comb begin
        w_ownRead  = 1'b0;
        w_ownWrite = 1'b0;
        w_ownAddr  = '0;
        w_ownWdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == 2'(i)) begin
                w_ownRead  = bus.s_do_read[i];
                w_ownWrite = bus.s_do_write[i];
                w_ownAddr  = bus.s_addr[i*AW +: AW];
                w_ownWdata = bus.s_wdata[i*32 +: 32];
            end
        end
    end

    assign w_nextPtr = (int'(r_owner) == NREQ - 1) ? 2'd0 : r_owner + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_rrPtr <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_ownRead && !w_ownWrite) begin
                        r_state <= ST_DRAIN;
                        r_rrPtr <= w_nextPtr;
                    end
                end
                ST_DRAIN: begin
                    if (bus.m_is_idle) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Only the owner's strobes reach the port; waiting requesters see not-idle until served.
    always_comb begin
        bus.s_next_word = '0;
        bus.s_is_idle   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == 2'(i) && r_state != ST_IDLE) begin
                bus.s_next_word[i] = w_grant & bus.m_next_word;
                bus.s_is_idle[i]   = bus.m_is_idle & (r_state == ST_DRAIN);
            end else begin
                bus.s_is_idle[i]   = ~w_req[i];
            end
        end
    end

    assign bus.m_do_read  = w_grant & w_ownRead;
    assign bus.m_do_write = w_grant & w_ownWrite;
    assign bus.m_addr     = w_ownAddr;
    assign bus.m_wdata    = w_ownWdata;
    assign bus.s_rdata    = bus.m_rdata;

    assign owner = r_owner;
    assign busy  = (r_state != ST_IDLE);
endmodule

// File: doc/qpi_mem_arbiter.md
Name: qpi_mem_arbiter

Overview:
- Round-robin arbiter that shares one QPI-style memory port (the SDRAM adapter's qpi_* interface) between NREQ requesters, e.g. the CPU cache and the DMA/blitter cache.
- Grants one requester for a whole burst, forwards its strobes, address and write data downstream, and routes rdata and next_word back to it.
- Holds the grant until the requester drops its strobes and the downstream port reports idle.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AW, 25, QPI address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- s_do_read  in  NREQ  per-requester read strobe.
- s_do_write  in  NREQ  per-requester write strobe.
- s_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- s_wdata  in  NREQ*32  flattened write data.
- s_rdata  out  32  read data, broadcast to all requesters.
- s_next_word  out  NREQ  per-requester word strobe.
- s_is_idle  out  NREQ  per-requester idle indication.
- m_do_read  out  1  downstream read strobe.
- m_do_write  out  1  downstream write strobe.
- m_addr  out  AW  downstream address.
- m_wdata  out  32  downstream write data.
- m_rdata  in  32  downstream read data.
- m_next_word  in  1  downstream word strobe.
- m_is_idle  in  1  downstream idle.
- owner  out  2  index of the current/last granted requester.
- busy  out  1  high in GRANT or DRAIN.

Behaviour:
- States: IDLE, GRANT, DRAIN. All state is registered: state, owner, rr_ptr.
- Reset values: state=IDLE, owner=0, rr_ptr=0, busy=0, m_do_read=0, m_do_write=0, s_next_word=0.
- A requester is "requesting" when s_do_read[i] | s_do_write[i].
- IDLE:
  - Pick the first requesting index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - If one is found: owner<=it, state<=GRANT.
  - Downstream strobes stay 0 in IDLE.
  - Grant latency: request at edge n, downstream strobe visible after edge n+1.
- GRANT:
  - m_do_read/m_do_write/m_addr/m_wdata are driven combinationally from requester[owner].
  - s_next_word[owner]=m_next_word; all other s_next_word bits are 0.
  - When the owner drops both strobes: state<=DRAIN; rr_ptr<=(owner+1) mod NREQ.
  - A requester never switches read to write without dropping strobes first, so it is never checked.
- DRAIN:
  - Downstream strobes are 0.
  - When m_is_idle=1: state<=IDLE.
  - The next grant can therefore occur no sooner than 2 cycles after the owner releases.
- Outside GRANT: m_addr and m_wdata hold requester[owner] values (don't-care); strobes are 0.
- s_rdata = m_rdata always.
- s_is_idle[i]:
  - If i==owner and state!=IDLE: m_is_idle & (state==DRAIN).
  - Otherwise: ~(s_do_read[i]|s_do_write[i]).
  - A waiting requester sees is_idle=0 until it is served.
- busy = (state!=IDLE).
- Simultaneous events:
  - A request from the owner arriving in the same cycle DRAIN exits is arbitrated fairly in IDLE. Rotation priority means another waiting requester wins.
  - A requester asserting strobes while another owns the port waits; nothing is forwarded.
- Fairness: with all NREQ requesting continuously, grants go owner+1, owner+2, ... No requester waits more than NREQ-1 bursts.
- Reset mid-burst: rst forces IDLE the next edge, so downstream strobes drop to 0 immediately after that edge. The downstream adapter is reset by the same rst.
- No combinational path from m_* inputs to m_* outputs.

Test Plan:
- Single read: s_do_read=01 at cycle 0, addr0=0x000100 → owner=0, m_do_read=1 and m_addr=0x000100 from cycle 1. Three m_next_word pulses appear only on s_next_word[0]. Req drops → DRAIN; m_is_idle=1 → IDLE. s_is_idle[0]=1 in DRAIN with m_is_idle.
- Contention: both requesters strobe at cycle 0 with rr_ptr=0 → req0 is served first. Req1 s_is_idle=0 throughout and m_addr never shows addr1. Req1 is granted 2 cycles after req0 releases with m_is_idle=1.
- Round-robin: both request continuously for 4 bursts → grant sequence 0,1,0,1.
- Write forwarding: req1 write, wdata=0xDEADBEEF, addr=0x1FFFFFC → m_do_write=1 with identical m_wdata/m_addr. m_do_read stays 0. s_next_word[0] stays 0.
- Slow drain: owner releases while m_is_idle=0 for 5 cycles → state stays DRAIN, strobes 0, no new grant until m_is_idle=1.
- Reset mid-burst: rst=1 during GRANT → next cycle state=IDLE, m_do_read=0, owner=0, busy=0. A pending request is re-granted after rst deasserts.
